// File: rtl/dest_reg_pipe.sv
// Write-destination unit: picks the register-file write address in ID and carries it,
// with its write enable, through the EX..WB pipeline registers for forwarding and hazard checks.
module dest_reg_pipe #(
    parameter int REG_ADDR_W = 5,
    parameter int STAGES     = 3,
    parameter int LINK_REG   = 31
) (
    input  logic                         i_clk,
    input  logic                         i_reset_n,
    input  logic [REG_ADDR_W-1:0]        i_rt,
    input  logic [REG_ADDR_W-1:0]        i_rd,
    input  logic [1:0]                   i_dst_sel,
    input  logic                         i_reg_write,
    input  logic                         i_valid,
    input  logic                         i_hold,
    input  logic                         i_bubble,
    input  logic [REG_ADDR_W-1:0]        i_rs_src,
    input  logic [REG_ADDR_W-1:0]        i_rt_src,
    output logic [STAGES*REG_ADDR_W-1:0] o_dst,
    output logic [STAGES-1:0]            o_wr_en,
    output logic [REG_ADDR_W-1:0]        o_dst_wb,
    output logic                         o_wr_en_wb,
    output logic [STAGES-1:0]            o_rs_hit,
    output logic [STAGES-1:0]            o_rt_hit
);

    localparam logic [REG_ADDR_W-1:0] LINK_ADDR = LINK_REG[REG_ADDR_W-1:0];

    typedef enum logic [1:0] {
        SEL_RD       = 2'b00,
        SEL_RT       = 2'b01,
        SEL_LINK     = 2'b10,
        SEL_RESERVED = 2'b11
    } dst_sel_e;

    logic [REG_ADDR_W-1:0] sel_addr;
    logic                  sel_we;
    logic [REG_ADDR_W-1:0] dst_q [STAGES];
    logic [STAGES-1:0]     we_q;

    // The reserved encoding and any write aimed at $0 never produce a write enable.
    always_comb begin
        sel_addr = '0;
        unique case (dst_sel_e'(i_dst_sel))
            SEL_RD:       sel_addr = i_rd;
            SEL_RT:       sel_addr = i_rt;
            SEL_LINK:     sel_addr = LINK_ADDR;
            SEL_RESERVED: sel_addr = '0;
            default:      sel_addr = '0;
        endcase
        sel_we = i_valid & i_reg_write & (i_dst_sel != SEL_RESERVED) & (sel_addr != '0);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int k = 0; k < STAGES; k++) begin
                dst_q[k] <= '0;
            end
            we_q <= '0;
        end else if (!i_hold) begin
            dst_q[0] <= i_bubble ? '0 : sel_addr;
            we_q[0]  <= i_bubble ? 1'b0 : sel_we;
            for (int k = 1; k < STAGES; k++) begin
                dst_q[k] <= dst_q[k-1];
                we_q[k]  <= we_q[k-1];
            end
        end
    end

    // Hit flags are combinational so forwarding sees the current ID sources without delay.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        assign o_dst[k*REG_ADDR_W +: REG_ADDR_W] = dst_q[k];
        assign o_rs_hit[k] = we_q[k] & (dst_q[k] == i_rs_src);
        assign o_rt_hit[k] = we_q[k] & (dst_q[k] == i_rt_src);
    end

    assign o_wr_en    = we_q;
    assign o_dst_wb   = dst_q[STAGES-1];
    assign o_wr_en_wb = we_q[STAGES-1];

endmodule

// File: tb/tb_dest_reg_pipe.sv
// Directed bench for dest_reg_pipe with the default 3-stage, 5-bit configuration.
module tb_dest_reg_pipe;

    logic        i_clk;
    logic        i_reset_n;
    logic [4:0]  i_rt;
    logic [4:0]  i_rd;
    logic [1:0]  i_dst_sel;
    logic        i_reg_write;
    logic        i_valid;
    logic        i_hold;
    logic        i_bubble;
    logic [4:0]  i_rs_src;
    logic [4:0]  i_rt_src;
    logic [14:0] o_dst;
    logic [2:0]  o_wr_en;
    logic [4:0]  o_dst_wb;
    logic        o_wr_en_wb;
    logic [2:0]  o_rs_hit;
    logic [2:0]  o_rt_hit;

    int compared   = 0;
    int mismatched = 0;

    dest_reg_pipe #(.REG_ADDR_W(5), .STAGES(3), .LINK_REG(31)) dut (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_rt        (i_rt),
        .i_rd        (i_rd),
        .i_dst_sel   (i_dst_sel),
        .i_reg_write (i_reg_write),
        .i_valid     (i_valid),
        .i_hold      (i_hold),
        .i_bubble    (i_bubble),
        .i_rs_src    (i_rs_src),
        .i_rt_src    (i_rt_src),
        .o_dst       (o_dst),
        .o_wr_en     (o_wr_en),
        .o_dst_wb    (o_dst_wb),
        .o_wr_en_wb  (o_wr_en_wb),
        .o_rs_hit    (o_rs_hit),
        .o_rt_hit    (o_rt_hit)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drive one ID slot, take one rising edge, and settle just after it.
    task automatic applyStimulus(input logic [4:0] rt, input logic [4:0] rd, input logic [1:0] sel,
                                 input logic rw, input logic valid, input logic hold, input logic bubble);
        i_rt        = rt;
        i_rd        = rd;
        i_dst_sel   = sel;
        i_reg_write = rw;
        i_valid     = valid;
        i_hold      = hold;
        i_bubble    = bubble;
        @(posedge i_clk);
        #1;
    endtask

    task automatic checkAllClear(input string tag);
        checkOutput({tag, "_dst"}, {17'd0, o_dst}, 32'd0);
        checkOutput({tag, "_we"}, {29'd0, o_wr_en}, 32'd0);
        checkOutput({tag, "_wb"}, {26'd0, o_wr_en_wb, o_dst_wb}, 32'd0);
        checkOutput({tag, "_hits"}, {26'd0, o_rs_hit, o_rt_hit}, 32'd0);
    endtask

    initial begin
        i_reset_n = 1'b0;
        i_rs_src  = 5'd0;
        i_rt_src  = 5'd0;
        applyStimulus(5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset held with random activity on every input.
        for (int i = 0; i < 3; i++) begin
            i_rs_src = 5'($urandom);
            i_rt_src = 5'($urandom);
            applyStimulus(5'($urandom), 5'($urandom), 2'($urandom), 1'b1, 1'b1, 1'b0, 1'b0);
        end
        i_rs_src = 5'd31;
        i_rt_src = 5'd31;
        checkAllClear("reset_hold");
        i_reset_n = 1'b1;

        // R-type rd=8 walking EX -> MEM -> WB, with rs=8 forwarding hits.
        i_rs_src = 5'd8;
        i_rt_src = 5'd3;
        applyStimulus(5'd0, 5'd8, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("rtype_ex_dst", {17'd0, o_dst}, 32'd8);
        checkOutput("rtype_ex_we", {29'd0, o_wr_en}, 32'b001);
        checkOutput("hazard_rs_ex", {29'd0, o_rs_hit}, 32'b001);
        checkOutput("hazard_rt_ex", {29'd0, o_rt_hit}, 32'b000);
        applyStimulus(5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rtype_mem_dst", {17'd0, o_dst}, 32'd256);
        checkOutput("rtype_mem_we", {29'd0, o_wr_en}, 32'b010);
        checkOutput("hazard_rs_mem", {29'd0, o_rs_hit}, 32'b010);
        applyStimulus(5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rtype_wb", {26'd0, o_wr_en_wb, o_dst_wb}, {26'd0, 1'b1, 5'd8});
        checkOutput("rtype_wb_we", {29'd0, o_wr_en}, 32'b100);
        checkOutput("hazard_rs_wb", {29'd0, o_rs_hit}, 32'b100);

        // I-type rt=9, then JAL link register.
        i_rs_src = 5'd31;
        i_rt_src = 5'd9;
        applyStimulus(5'd9, 5'd4, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("itype_dst", {17'd0, o_dst}, 32'd9);
        checkOutput("itype_we", {29'd0, o_wr_en}, 32'b001);
        applyStimulus(5'd9, 5'd4, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("jal_dst", {17'd0, o_dst}, 32'd319);
        checkOutput("jal_we", {29'd0, o_wr_en}, 32'b011);
        checkOutput("jal_rs_hit", {29'd0, o_rs_hit}, 32'b001);
        checkOutput("jal_rt_hit", {29'd0, o_rt_hit}, 32'b010);

        // Writes to $0 and the reserved select are squashed; source 0 never hits.
        applyStimulus(5'd7, 5'd0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("zero_dst0", {27'd0, o_dst[4:0]}, 32'd0);
        checkOutput("zero_we", {29'd0, o_wr_en}, 32'b110);
        applyStimulus(5'd7, 5'd5, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("rsvd_dst", {17'd0, o_dst}, 32'd31744);
        checkOutput("rsvd_we", {29'd0, o_wr_en}, 32'b100);
        checkOutput("rsvd_wb_dst", {27'd0, o_dst_wb}, 32'd31);
        i_rs_src = 5'd0;
        i_rt_src = 5'd0;
        #1;
        checkOutput("src0_hits", {26'd0, o_rs_hit, o_rt_hit}, 32'd0);

        // Hold freezes everything, and dominates a simultaneous bubble.
        applyStimulus(5'd0, 5'd8, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(5'd0, 5'd12, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("prehold_dst", {17'd0, o_dst}, 32'd268);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(5'd0, 5'd20, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
            checkOutput("hold_dst", {17'd0, o_dst}, 32'd268);
            checkOutput("hold_we", {29'd0, o_wr_en}, 32'b011);
        end
        applyStimulus(5'd0, 5'd20, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("holdbub_dst", {17'd0, o_dst}, 32'd268);
        checkOutput("holdbub_we", {29'd0, o_wr_en}, 32'b011);
        applyStimulus(5'd0, 5'd20, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("bubble_dst", {17'd0, o_dst}, 32'd8576);
        checkOutput("bubble_we", {29'd0, o_wr_en}, 32'b110);

        // Invalid slot or RegWrite low never writes.
        applyStimulus(5'd0, 5'd3, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("invalid_we", {29'd0, o_wr_en}, 32'b100);
        applyStimulus(5'd0, 5'd3, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("norw_we", {29'd0, o_wr_en}, 32'b000);

        // Mid-stream reset clears before the next edge; capture resumes after release.
        applyStimulus(5'd0, 5'd6, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(5'd0, 5'd7, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("premid_we", {29'd0, o_wr_en}, 32'b011);
        i_rs_src  = 5'd7;
        i_rt_src  = 5'd6;
        i_reset_n = 1'b0;
        #2;
        checkAllClear("mid_reset");
        applyStimulus(5'd0, 5'd9, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        checkAllClear("mid_reset_edge");
        i_reset_n = 1'b1;
        applyStimulus(5'd0, 5'd8, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("post_reset_dst", {17'd0, o_dst}, 32'd8);
        checkOutput("post_reset_we", {29'd0, o_wr_en}, 32'b001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
